// File: rtl/rp_seek.sv
// rp_seek: per-drive head positioner for the RPxx disk emulation.
// A seek or recalibrate command steps the current cylinder toward the target
// at one cylinder per STEP_DLY clocks. After arrival the positioner settles
// for SETTLE_DLY clocks, then gives a one-cycle attention pulse. A seek to a
// cylinder past CYL_MAX sets the sticky invalid-address error instead.
module rp_seek #(
  parameter int CYL_MAX    = 814,
  parameter int STEP_DLY   = 100,
  parameter int SETTLE_DLY = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [9:0]  rpDCA,
  input  logic        go_seek,
  input  logic        go_recal,
  output logic [15:0] rpCC,
  output logic        busy,
  output logic        ata,
  output logic        iae
);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    SETTLE
  } state_t;

  localparam logic [15:0] STEP_LOAD   = 16'(STEP_DLY - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_DLY - 1);
  localparam logic [9:0]  CYL_LIMIT   = 10'(CYL_MAX);

  state_t      state, state_d;
  logic [9:0]  cc, cc_d;
  logic [9:0]  tgt, tgt_d;
  logic [15:0] cnt, cnt_d;
  logic        busy_d, ata_d, iae_d;

  logic [9:0]  cmd_tgt;
  logic [9:0]  cc_step;

  assign rpCC = {6'b0, cc};

  // State and registered outputs; rst forces everything back to the idle,
  // cylinder-zero condition at once, even mid-seek.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cc    <= '0;
      tgt   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      ata   <= 1'b0;
      iae   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous cycle, independent of statement order.
      state <= state_d;
      cc    <= cc_d;
      tgt   <= tgt_d;
      cnt   <= cnt_d;
      busy  <= busy_d;
      ata   <= ata_d;
      iae   <= iae_d;
    end
  end

  // Next-state logic: clear, command acceptance, stepping and settling.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case statement leaves a value unassigned (no latches).
    state_d = state;
    cc_d    = cc;
    tgt_d   = tgt;
    cnt_d   = cnt;
    busy_d  = busy;
    ata_d   = 1'b0;
    iae_d   = iae;
    cmd_tgt = go_recal ? 10'd0 : rpDCA;
    cc_step = (tgt > cc) ? cc + 10'd1 : cc - 10'd1;

    if (clr) begin
      // Drive clear aborts the operation without moving the heads.
      state_d = IDLE;
      busy_d  = 1'b0;
      iae_d   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go_recal || go_seek) begin
            if (!go_recal && (rpDCA > CYL_LIMIT)) begin
              // Out-of-range seek: flag it and report completion right away.
              iae_d = 1'b1;
              ata_d = 1'b1;
            end else begin
              tgt_d  = cmd_tgt;
              busy_d = 1'b1;
              if (cmd_tgt != cc) begin
                cnt_d   = STEP_LOAD;
                state_d = STEP;
              end else begin
                cnt_d   = SETTLE_LOAD;
                state_d = SETTLE;
              end
            end
          end
        end

        STEP: begin
          if (cnt != 16'd0) begin
            cnt_d = cnt - 16'd1;
          end else begin
            cc_d = cc_step;
            if (cc_step == tgt) begin
              cnt_d   = SETTLE_LOAD;
              state_d = SETTLE;
            end else begin
              cnt_d = STEP_LOAD;
            end
          end
        end

        SETTLE: begin
          if (cnt != 16'd0) begin
            cnt_d = cnt - 16'd1;
          end else begin
            busy_d  = 1'b0;
            ata_d   = 1'b1;
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rp_seek.md
# rp_seek

Per-drive head positioner model for the RPxx disk emulation. On a seek or recalibrate command it consumes the 10-bit desired cylinder address and steps the current cylinder toward it at a fixed per-cylinder rate. It then waits a settle time and signals completion with a one-cycle attention pulse. It is the reading side of the desired-cylinder register: it produces the current-cylinder value, the positioner-busy status and the invalid-address error for the drive's status logic.

## Interface
- CYL_MAX, 814: highest legal cylinder. The RP06 has 815 cylinders, 0..814.
- STEP_DLY, 100: clocks per one-cylinder step; must be >= 1.
- SETTLE_DLY, 500: clocks of settle time after arrival; must be >= 1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  drive clear, synchronous.
- rpDCA  in  10  desired cylinder address.
- go_seek  in  1  seek command strobe, one cycle.
- go_recal  in  1  recalibrate command strobe, one cycle.
- rpCC  out  16  current cylinder, formed as {6'b0, cc[9:0]}.
- busy  out  1  positioner in motion or settling.
- ata  out  1  attention, one-cycle completion pulse.
- iae  out  1  invalid address error; sticky.

## Operation
- States:
  - IDLE: waiting for a command.
  - STEP: counting one step interval, then moving one cylinder.
  - SETTLE: counting the settle time.
- Reset (rst): state IDLE; cc=0, busy=0, ata=0, iae=0; counter=0.
- clr, any state, takes priority over commands:
  - state goes to IDLE; busy=0, ata=0, iae=0.
  - cc is unchanged; drive clear does not move the heads.
  - no ata is generated for the aborted operation.
- Command acceptance (IDLE only):
  - go_recal takes priority over go_seek when both are asserted.
  - recal target = 0.
  - seek target = rpDCA, latched at acceptance. Later changes to rpDCA do not affect an operation in progress.
- Seek with target > CYL_MAX:
  - iae<=1 and ata pulses on the next cycle.
  - state stays IDLE; busy stays 0; cc is unchanged.
  - recalibrate can never set iae.
- Valid target, target != cc: busy<=1, counter<=STEP_DLY-1, state goes to STEP.
- Valid target, target == cc: busy<=1, counter<=SETTLE_DLY-1, state goes to SETTLE.
- STEP:
  - counter != 0: decrement.
  - counter == 0: cc<=cc+1 if target>cc, else cc-1.
  - If the new cc == target: counter<=SETTLE_DLY-1, state goes to SETTLE.
  - Otherwise: counter<=STEP_DLY-1 and stay in STEP.
- SETTLE:
  - counter != 0: decrement.
  - counter == 0: busy<=0, ata<=1 for one cycle, state goes to IDLE.
- Commands while busy=1 are ignored without error and are not queued.
- An existing iae does not block later commands. iae is cleared only by clr or rst.
- Arithmetic:
  - cc is 10-bit unsigned and never wraps. It stays in 0..CYL_MAX because the target is range-checked.
  - target compare is unsigned, 10 bits.
  - delay counter is 16 bits; STEP_DLY and SETTLE_DLY must be <= 65536.

## Timing
- All outputs are registered. Edge E0 is the edge that samples the command.
- Seek over distance d > 0:
  - busy=1 after E0.
  - cc changes after edges E0+k*STEP_DLY, for k=1..d.
  - ata=1 and busy=0 after edge E0+d*STEP_DLY+SETTLE_DLY.
  - ata deasserts one edge later.
- Zero-distance seek: ata and busy fall after edge E0+SETTLE_DLY.
- Invalid address: iae=1 and ata=1 after E0; ata deasserts after E0+1.
- A new command may be accepted on the edge immediately after ata rises, because state is already IDLE.
- rst asserted mid-operation forces the reset values immediately, including cc=0.

## Test plan
Bench parameters: STEP_DLY=4, SETTLE_DLY=8.
- Reset: assert rst -> rpCC=0, busy=0, ata=0, iae=0. Release rst -> all outputs hold these values.
- Seek 0->3: rpDCA=3, go_seek at E0 -> busy=1 after E0; rpCC=1, 2, 3 after E0+4, +8, +12; single ata pulse and busy=0 after E0+20.
- Recal and priority: from cc=3, go_seek with rpDCA=5 and go_recal asserted together -> rpCC=2, 1, 0 at +4, +8, +12; ata at +20; no movement toward 5.
- Invalid address: rpDCA=815, go_seek -> iae=1 and a one-cycle ata after E0; busy stays 0; rpCC unchanged. Pulse clr -> iae=0. A following valid seek to 2 completes normally.
- Zero distance: rpDCA equal to cc=2, go_seek -> busy for 8 cycles; ata after E0+8; rpCC stays 2.
- Abort and lockout:
  - seek 0->5; at E0+2 pulse go_seek with rpDCA=1 -> ignored.
  - clr at E0+6 (after the first step) -> busy=0, rpCC stays 1, no ata ever appears.
  - changing rpDCA mid-seek has no effect.
